// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard tracker for the in-order pipeline.
// Keeps a shadow of the destination of every register write still in flight
// in the DEPTH stages after decode, substitutes the youngest in-flight result
// for each source operand, and stalls decode while a late-produced result
// is not yet available.
module fwd_hazard_unit #(
  parameter int DATA_W     = 16,
  parameter int RADDR_W    = 3,
  parameter int DEPTH      = 3,
  parameter int LATE_STAGE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    issue_valid,
  input  logic [RADDR_W-1:0]      issue_dest,
  input  logic                    issue_we,
  input  logic                    issue_late,
  input  logic                    flush,
  input  logic [DEPTH*DATA_W-1:0] stage_result,
  input  logic                    srcA_used,
  input  logic [RADDR_W-1:0]      srcA_addr,
  input  logic [DATA_W-1:0]       rfA_data,
  input  logic                    srcB_used,
  input  logic [RADDR_W-1:0]      srcB_addr,
  input  logic [DATA_W-1:0]       rfB_data,
  output logic [DATA_W-1:0]       opA_data,
  output logic [DATA_W-1:0]       opB_data,
  output logic                    fwdA_hit,
  output logic                    fwdB_hit,
  output logic                    stall,
  output logic [15:0]             stall_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Result of searching the tracker for one source operand.
  typedef struct packed {
    logic             hit;   // youngest match is ready: forward it
    logic             pend;  // youngest match is late and not ready: stall
    logic [IDX_W-1:0] idx;   // entry index of the youngest match
  } lookup_t;

  // Tracker entries; index 0 is the youngest (output of the first stage).
  logic [DEPTH-1:0]              entValid_r;
  logic [DEPTH-1:0]              entLate_r;
  logic [DEPTH-1:0][RADDR_W-1:0] entDest_r;
  logic [15:0]                   stallCount_r;

  logic [DATA_W-1:0] slice_s [DEPTH];
  lookup_t           lkA_s;
  lookup_t           lkB_s;
  logic              stall_s;

  // Walk from oldest to youngest so the youngest match overrides older ones;
  // a ready younger match therefore masks an older pending one.
  function automatic lookup_t lookup(
    input logic                              used,
    input logic [RADDR_W-1:0]                addr,
    input logic [DEPTH-1:0]                  vld,
    input logic [DEPTH-1:0]                  late,
    input logic [DEPTH-1:0][RADDR_W-1:0]     dest
  );
    lookup_t res;
    lookup_t cand;
    logic    match;
    logic    ready;
    res = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      match     = used & vld[i] & (dest[i] == addr);
      ready     = ~(late[i] & (i < LATE_STAGE));
      cand.hit  = ready;
      cand.pend = ~ready;
      cand.idx  = IDX_W'(i);
      res       = match ? cand : res;
    end
    return res;
  endfunction

  // Split the flat stage result bus into one word per tracker entry.
  for (genvar g = 0; g < DEPTH; g++) begin : gSlice
    assign slice_s[g] = stage_result[g*DATA_W +: DATA_W];
  end

  // Combinational search of the tracker for both operands.
  always_comb begin
    lkA_s = lookup(srcA_used, srcA_addr, entValid_r, entLate_r, entDest_r);
    lkB_s = lookup(srcB_used, srcB_addr, entValid_r, entLate_r, entDest_r);
  end

  // A pending operand only matters when decode actually issues.
  assign stall_s  = issue_valid & (lkA_s.pend | lkB_s.pend);

  assign fwdA_hit = lkA_s.hit;
  assign fwdB_hit = lkB_s.hit;
  // While stalled the operand value is unused; the register-file value is passed.
  assign opA_data = lkA_s.hit ? slice_s[lkA_s.idx] : rfA_data;
  assign opB_data = lkB_s.hit ? slice_s[lkB_s.idx] : rfB_data;
  assign stall       = stall_s;
  assign stall_count = stallCount_r;

  // Advance the tracker every cycle; a stalled or squashed issue becomes a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entValid_r <= '0;
      entLate_r  <= '0;
      entDest_r  <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entValid_r[i] <= entValid_r[i-1];
        entLate_r[i]  <= entLate_r[i-1];
        entDest_r[i]  <= entDest_r[i-1];
      end
      entValid_r[0] <= issue_valid & issue_we & ~flush & ~stall_s;
      entLate_r[0]  <= issue_late;
      entDest_r[0]  <= issue_dest;
    end
  end

  // Saturating count of stalled cycles; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCount_r <= 16'h0000;
    end else if (stall_s && (stallCount_r != 16'hFFFF)) begin
      stallCount_r <= stallCount_r + 16'h0001;
    end else begin
      stallCount_r <= stallCount_r;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: directed vectors push their expected
// response into a queue, and a monitor pops and compares on each sample point.
// A second, deep instance is left stalling on its own to reach saturation.
module tb_fwd_hazard_unit;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DP = 3;
  localparam int LS = 1;
  localparam int SDP = 32;
  localparam int SLS = 31;

  logic              clk;
  logic              reset;
  logic              issue_valid;
  logic [AW-1:0]     issue_dest;
  logic              issue_we;
  logic              issue_late;
  logic              flush;
  logic [DP*DW-1:0]  stage_result;
  logic              srcA_used;
  logic [AW-1:0]     srcA_addr;
  logic [DW-1:0]     rfA_data;
  logic              srcB_used;
  logic [AW-1:0]     srcB_addr;
  logic [DW-1:0]     rfB_data;
  logic [DW-1:0]     opA_data;
  logic [DW-1:0]     opB_data;
  logic              fwdA_hit;
  logic              fwdB_hit;
  logic              stall;
  logic [15:0]       stall_count;

  logic              satReset;
  logic [DW-1:0]     satOpA;
  logic [DW-1:0]     satOpB;
  logic              satHitA;
  logic              satHitB;
  logic              satStall;
  logic [15:0]       satCount;
  logic [SDP*DW-1:0] satResult;

  logic probe;
  int   vectors;
  int   miscompares;
  int   nextId;

  typedef struct {
    int          id;
    bit          sat;
    bit          chkOps;
    logic [15:0] opA;
    logic [15:0] opB;
    bit          chkHits;
    logic        hitA;
    logic        hitB;
    logic        stl;
    logic [15:0] cnt;
  } exp_t;

  exp_t expQ[$];

  fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .DEPTH(DP), .LATE_STAGE(LS)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_we(issue_we),
    .issue_late(issue_late), .flush(flush), .stage_result(stage_result),
    .srcA_used(srcA_used), .srcA_addr(srcA_addr), .rfA_data(rfA_data),
    .srcB_used(srcB_used), .srcB_addr(srcB_addr), .rfB_data(rfB_data),
    .opA_data(opA_data), .opB_data(opB_data), .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit),
    .stall(stall), .stall_count(stall_count)
  );

  // Deep instance with constant inputs: a late write to r1 that it keeps re-reading,
  // giving 31 stall cycles in every 32.
  fwd_hazard_unit #(.DATA_W(DW), .RADDR_W(AW), .DEPTH(SDP), .LATE_STAGE(SLS)) satDut (
    .clk(clk), .reset(satReset),
    .issue_valid(1'b1), .issue_dest(3'd1), .issue_we(1'b1),
    .issue_late(1'b1), .flush(1'b0), .stage_result(satResult),
    .srcA_used(1'b1), .srcA_addr(3'd1), .rfA_data(16'h0000),
    .srcB_used(1'b0), .srcB_addr(3'd0), .rfB_data(16'h0000),
    .opA_data(satOpA), .opB_data(satOpB), .fwdA_hit(satHitA), .fwdB_hit(satHitB),
    .stall(satStall), .stall_count(satCount)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int id, input string what, input logic [15:0] act, input logic [15:0] want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL vec%0d %s: got %h, wanted %h", id, what, act, want);
    end
  endtask

  // Monitor: compare the oldest pending expectation at each sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge probe);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        vectors++;
        if (e.sat) begin
          chk(e.id, "satCount", satCount, e.cnt);
        end else begin
          chk(e.id, "stall", {15'd0, stall}, {15'd0, e.stl});
          chk(e.id, "stall_count", stall_count, e.cnt);
          if (e.chkHits) begin
            chk(e.id, "fwdA_hit", {15'd0, fwdA_hit}, {15'd0, e.hitA});
            chk(e.id, "fwdB_hit", {15'd0, fwdB_hit}, {15'd0, e.hitB});
          end
          if (e.chkOps) begin
            chk(e.id, "opA_data", opA_data, e.opA);
            chk(e.id, "opB_data", opB_data, e.opB);
          end
        end
      end
    end
  end

  task automatic pushExp(input bit chkOps, input logic [15:0] oA, input logic [15:0] oB,
                         input bit chkHits, input logic hA, input logic hB,
                         input logic st, input logic [15:0] cnt);
    exp_t e;
    e.id = nextId; e.sat = 1'b0; e.chkOps = chkOps; e.opA = oA; e.opB = oB;
    e.chkHits = chkHits; e.hitA = hA; e.hitB = hB; e.stl = st; e.cnt = cnt;
    nextId++;
    expQ.push_back(e);
  endtask

  task automatic pushSat(input logic [15:0] cnt);
    exp_t e;
    e = '{id: nextId, sat: 1'b1, chkOps: 1'b0, opA: 16'h0000, opB: 16'h0000,
          chkHits: 1'b0, hitA: 1'b0, hitB: 1'b0, stl: 1'b0, cnt: cnt};
    nextId++;
    expQ.push_back(e);
  endtask

  task automatic setIssue(input logic v, input logic we, input logic [AW-1:0] d,
                          input logic lt, input logic fl);
    issue_valid = v; issue_we = we; issue_dest = d; issue_late = lt; flush = fl;
  endtask

  task automatic setSrc(input logic aU, input logic [AW-1:0] aA,
                        input logic bU, input logic [AW-1:0] bA);
    srcA_used = aU; srcA_addr = aA; srcB_used = bU; srcB_addr = bA;
  endtask

  task automatic setSlices(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2);
    stage_result = {s2, s1, s0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [15:0] RFA = 16'h0A0A;
  localparam logic [15:0] RFB = 16'h0B0B;

  // Directed stimulus; each step commits the current vector on the next rising edge.
  initial begin
    vectors = 0; miscompares = 0; nextId = 0; probe = 1'b0;
    reset = 1'b1; satReset = 1'b1; satResult = '0;
    rfA_data = RFA; rfB_data = RFB;
    setIssue(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    setSlices(16'h0000, 16'h0000, 16'h0000);
    setSrc(1'b1, 3'd3, 1'b1, 3'd5);
    #2;
    // reset state: nothing tracked, register-file data passes through
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk); #1 reset = 1'b0;
    step();

    // V1: issue r3
    setSrc(1'b0, 3'd0, 1'b0, 3'd0);
    setIssue(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    // V2: back-to-back dependency on r3, and issue r3 again
    setSrc(1'b1, 3'd3, 1'b0, 3'd0);
    setSlices(16'h1234, 16'h0000, 16'h0000);
    pushExp(1'b1, 16'h1234, RFB, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    // V3: entries 0 and 1 both r3 -> youngest wins on both operands
    setIssue(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    setSrc(1'b1, 3'd3, 1'b1, 3'd3);
    setSlices(16'hAAAA, 16'hBBBB, 16'h0000);
    pushExp(1'b1, 16'hAAAA, 16'hAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    // V4: entry0 empty, entries 1 and 2 r3 -> entry1
    setSlices(16'h1111, 16'hCCCC, 16'hDDDD);
    pushExp(1'b1, 16'hCCCC, 16'hCCCC, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    step();
    // V5: only entry2 (oldest) is r3 -> still forwarded; B unused -> no hit
    setSrc(1'b1, 3'd3, 1'b0, 3'd3);
    setSlices(16'h1111, 16'h2222, 16'hDDDD);
    pushExp(1'b1, 16'hDDDD, RFB, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    // V6: r3 aged out; issue r4 with we=0
    setSrc(1'b1, 3'd3, 1'b0, 3'd0);
    setIssue(1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    // V7: read r4 -> no false hazard; issue late r5
    setSrc(1'b1, 3'd4, 1'b0, 3'd0);
    setIssue(1'b1, 1'b1, 3'd5, 1'b1, 1'b0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    // V8: read r5 while it sits late in entry0 -> stall
    setSrc(1'b0, 3'd0, 1'b1, 3'd5);
    setIssue(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    pushExp(1'b0, RFA, RFB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    // V9: r5 now in entry1 -> forwarded, stall released, one stall counted
    setSlices(16'h0000, 16'h5555, 16'h0000);
    pushExp(1'b1, RFA, 16'h5555, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001);
    step();
    // V10: r6 in entry0, r5 in entry2; squash an issue of r2
    setIssue(1'b1, 1'b1, 3'd2, 1'b0, 1'b1);
    setSrc(1'b1, 3'd6, 1'b1, 3'd5);
    setSlices(16'h6666, 16'h0000, 16'h7777);
    pushExp(1'b1, 16'h6666, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001);
    step();
    // V11: squashed r2 is not tracked
    setIssue(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    setSrc(1'b1, 3'd2, 1'b0, 3'd0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
    step();
    // V12: issue late r7
    setSrc(1'b0, 3'd0, 1'b0, 3'd0);
    setIssue(1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
    step();
    // V13: both operands need r7 -> stall
    setIssue(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    setSrc(1'b1, 3'd7, 1'b1, 3'd7);
    pushExp(1'b0, RFA, RFB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);
    // V14: reset mid-stall while the clock is low -> cleared with no edge
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    probe = 1'b1;
    #1 probe = 1'b0;
    reset = 1'b0;
    step();
    // V15: issue late r1
    setIssue(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    setSrc(1'b1, 3'd7, 1'b0, 3'd0);
    pushExp(1'b1, RFA, RFB, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    // V16: stall and flush together on r1
    setIssue(1'b1, 1'b1, 3'd1, 1'b0, 1'b1);
    setSrc(1'b1, 3'd1, 1'b0, 3'd0);
    pushExp(1'b0, RFA, RFB, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step();
    // V17: entry1 (older, untouched by flush) now ready; issue late r1 again
    setIssue(1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    setSlices(16'h0000, 16'h9999, 16'h0000);
    pushExp(1'b1, 16'h9999, RFB, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001);
    step();
    // V18: pending r1 in entry0 but nothing issues -> no stall
    setIssue(1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
    pushExp(1'b0, RFA, RFB, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001);
    step();
    setSrc(1'b0, 3'd0, 1'b0, 3'd0);
    setIssue(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Saturation on the deep instance: 31 stalls per 32 cycles after release.
    @(negedge clk);
    #1 satReset = 1'b0;
    repeat (32) @(posedge clk);
    #1 pushSat(16'd31);
    repeat (65536 - 32) @(posedge clk);
    #1 pushSat(16'hF800);
    repeat (4096) @(posedge clk);
    #1 pushSat(16'hFFFF);
    repeat (64) @(posedge clk);
    #1 pushSat(16'hFFFF);

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors, wanted 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
